// File: rtl/ps2_key_event_gen.sv
// PS/2 keyboard receiver that assembles scancode sequences into the 65-bit key-event word.
// Optional frame timeout is compiled in with `define PS2_KEY_TIMEOUT_EN.
module ps2_key_event_gen #(
    parameter int FILT_LEN = 8,
    parameter int TIMEOUT  = 24000
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [64:0] ps2_key,
    output logic        frame_err,
    output logic        busy
);

    localparam int FCW = (FILT_LEN > 1) ? $clog2(FILT_LEN + 1) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [7:0] CODE_E0 = 8'hE0;
    localparam logic [7:0] CODE_F0 = 8'hF0;
    localparam logic [7:0] CODE_E1 = 8'hE1;

    // ------------------------------------------------------------------
    // Input synchronizers (idle-high lines, so reset to 1)
    // ------------------------------------------------------------------
    logic clk_meta_q, clk_sync_q;
    logic dat_meta_q, dat_sync_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= ps2_data;
            dat_sync_q <= dat_meta_q;
        end
    end

    // ------------------------------------------------------------------
    // Clock glitch filter: level flips after FILT_LEN differing samples
    // ------------------------------------------------------------------
    logic           filt_q, filt_d;
    logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
    logic           fall;

    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        fall       = 1'b0;
        if (clk_sync_q != filt_q) begin
            if (filt_cnt_q == FCW'(FILT_LEN - 1)) begin
                filt_d = clk_sync_q;
                fall   = filt_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM, stepped only by filtered falling edges
    // ------------------------------------------------------------------
    logic [1:0] state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       perr_q, perr_d;
    logic       byte_ok;
    logic       stop_err;
    logic       tmo_hit;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        byte_ok   = 1'b0;
        stop_err  = 1'b0;
        if (fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!dat_sync_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 3'd0;
                        perr_d    = 1'b0;
                    end
                end
                ST_DATA: begin
                    shift_d   = {dat_sync_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    // Odd parity: the nine bits together must XOR to 1.
                    perr_d  = ~(^{shift_q, dat_sync_q});
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (dat_sync_q && !perr_q) begin
                        byte_ok = 1'b1;
                    end else begin
                        stop_err = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
`ifdef PS2_KEY_TIMEOUT_EN
        if (tmo_hit) begin
            state_d = ST_IDLE;
        end
`endif
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
        end
    end

`ifdef PS2_KEY_TIMEOUT_EN
    // ------------------------------------------------------------------
    // Frame timeout: a fall always reloads, so it wins over expiry
    // ------------------------------------------------------------------
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        tmo_hit   = 1'b0;
        if (fall || state_q == ST_IDLE) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q == TW'(TIMEOUT - 1)) begin
            tmo_hit   = 1'b1;
            tmo_cnt_d = '0;
        end else begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Event assembly
    // ------------------------------------------------------------------
    logic [63:0] acc_q, acc_d;
    logic [2:0]  pause_q, pause_d;
    logic [64:0] key_q, key_d;
    logic        err_q, err_d;
    logic [63:0] acc_shifted;
    logic        complete;

    assign acc_shifted = {acc_q[55:0], shift_q};

    always_comb begin
        acc_d    = acc_q;
        pause_d  = pause_q;
        key_d    = key_q;
        err_d    = stop_err | tmo_hit;
        complete = 1'b0;
        if (stop_err || tmo_hit) begin
            acc_d   = 64'h0;
            pause_d = 3'd0;
        end else if (byte_ok) begin
            // pause_q counts bytes already captured since E1; 0 means no Pause.
            if (pause_q != 3'd0) begin
                if (pause_q == 3'd7) begin
                    complete = 1'b1;
                end else begin
                    pause_d = pause_q + 3'd1;
                    acc_d   = acc_shifted;
                end
            end else if (shift_q == CODE_E1) begin
                pause_d = 3'd1;
                acc_d   = acc_shifted;
            end else if (shift_q == CODE_E0 || shift_q == CODE_F0) begin
                acc_d = acc_shifted;
            end else begin
                complete = 1'b1;
            end
            if (complete) begin
                key_d   = {~key_q[64], acc_shifted};
                acc_d   = 64'h0;
                pause_d = 3'd0;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            acc_q   <= 64'h0;
            pause_q <= 3'd0;
            key_q   <= 65'h0;
            err_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            pause_q <= pause_d;
            key_q   <= key_d;
            err_q   <= err_d;
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = err_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ps2_key_event_gen.sv
// Directed bench for ps2_key_event_gen: scancode frames in, key events checked against a queue.
// Timeout scenario is only exercised when PS2_KEY_TIMEOUT_EN is defined.
module tb_ps2_key_event_gen;

  localparam int HALF = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [64:0] ps2_key;
  logic        frame_err;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;
  int ev_cnt = 0;
  int err_cnt = 0;
  int exp_ev = 0;
  int exp_err = 0;
  logic last_tog = 1'b0;
  logic [63:0] exp_q[$];

  ps2_key_event_gen #(.FILT_LEN(8), .TIMEOUT(24000)) dut (
    .CLK      (clk),
    .RESET    (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .ps2_key  (ps2_key),
    .frame_err(frame_err),
    .busy     (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: every toggle of bit 64 pops one expected event
  always @(negedge clk) begin
    if (rst) begin
      last_tog = 1'b0;
    end else begin
      if (frame_err === 1'b1) err_cnt++;
      if (ps2_key[64] !== last_tog) begin
        last_tog = ps2_key[64];
        ev_cnt++;
        vectors++;
        assert (exp_q.size() != 0) else begin
          miscompares++;
          $error("FAIL unexpected_event: observed %h expected no event", ps2_key[63:0]);
        end
        if (exp_q.size() != 0) check("event_key", {1'b0, ps2_key[63:0]}, {1'b0, exp_q.pop_front()});
      end
    end
  end

  // driver tasks
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic ps2_pulse(input logic bit_v);
    ps2_data = bit_v;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_pulse(f[i]);
    ps2_data = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic send_good(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0);
  endtask

  task automatic send_partial(input int nbits);
    ps2_pulse(1'b0);
    for (int i = 0; i < nbits; i++) ps2_pulse(1'b1);
    ps2_data = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic check_counts(input string tag);
    wait_clk(4);
    @(negedge clk);
    check({tag, "_events"}, 65'(ev_cnt), 65'(exp_ev));
    check({tag, "_errors"}, 65'(err_cnt), 65'(exp_err));
    check({tag, "_busy"}, 65'(busy), 65'(0));
  endtask

  initial begin
    logic [7:0] pause_seq [8];
    pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    // reset state
    wait_clk(5);
    @(negedge clk);
    check("reset_key", ps2_key, 65'h0);
    check("reset_err", 65'(frame_err), 65'(0));
    check("reset_busy", 65'(busy), 65'(0));
    rst = 1'b0;
    wait_clk(5);

    // make code
    exp_q.push_back(64'h1C); exp_ev++;
    send_good(8'h1C);
    check_counts("make");
    check("make_toggle", 65'(ps2_key[64]), 65'(1));
    check("make_key16", 65'(ps2_key[15:0]), 65'h001C);

    // break sequence
    exp_q.push_back(64'hF01C); exp_ev++;
    send_good(8'hF0);
    send_good(8'h1C);
    check_counts("break");
    check("break_toggle", 65'(ps2_key[64]), 65'(0));

    // extended break
    exp_q.push_back(64'hE0F075); exp_ev++;
    send_good(8'hE0);
    send_good(8'hF0);
    send_good(8'h75);
    check_counts("ext_break");

    // pause sequence
    exp_q.push_back(64'hE11477E1F014F077); exp_ev++;
    for (int i = 0; i < 8; i++) send_good(pause_seq[i]);
    check_counts("pause");
    check("pause_key", {1'b0, ps2_key[63:0]}, {1'b0, 64'hE11477E1F014F077});

    // bad parity drops the pending prefix
    exp_q.push_back(64'h2A); exp_ev++; exp_err++;
    send_good(8'hF0);
    send_frame(8'h1C, 1'b1, 1'b0);
    send_good(8'h2A);
    check_counts("bad_parity");
    check("bad_parity_toggle", 65'(ps2_key[64]), 65'(1));

    // bad stop bit: error, no event
    exp_err++;
    send_frame(8'h1C, 1'b0, 1'b1);
    check_counts("bad_stop");

    // accumulator overflow keeps the newest eight bytes
    exp_q.push_back(64'hE0E0E0E0E0E0E01C); exp_ev++;
    for (int i = 0; i < 9; i++) send_good(8'hE0);
    send_good(8'h1C);
    check_counts("overflow");

    // spurious edge with data high is ignored
    ps2_pulse(1'b1);
    wait_clk(HALF);
    check_counts("spurious");
    exp_q.push_back(64'h5A); exp_ev++;
    send_good(8'h5A);
    check_counts("after_spurious");

`ifdef PS2_KEY_TIMEOUT_EN
    // truncated frame aborted by timeout
    exp_err++;
    send_partial(4);
    wait_clk(24010);
    check_counts("timeout");
    check("timeout_key", ps2_key, {1'b1, 64'h5A});
    exp_q.push_back(64'h2A); exp_ev++;
    send_good(8'h2A);
    check_counts("after_timeout");
`endif

    // reset mid-frame
    send_partial(4);
    @(negedge clk);
    check("midframe_busy", 65'(busy), 65'(1));
    rst = 1'b1;
    wait_clk(2);
    @(negedge clk);
    check("midreset_key", ps2_key, 65'h0);
    check("midreset_err", 65'(frame_err), 65'(0));
    check("midreset_busy", 65'(busy), 65'(0));
    rst = 1'b0;
    wait_clk(5);
    exp_q.push_back(64'h1C); exp_ev++;
    send_good(8'h1C);
    check_counts("after_reset");
    check("after_reset_toggle", 65'(ps2_key[64]), 65'(1));

    check("queue_drained", 65'(exp_q.size()), 65'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
